// File: rtl/ifetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_t;

  localparam int unsigned DEF_RESET_PC        = 0;
  localparam int unsigned DEF_INSTR_BYTES     = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-side bus: the pipeline (master) drives control/redirect, the fetch unit (slave) drives PC and status.
// Optional misalign signal present when IFETCH_ALIGN_CHECK_EN is defined.
interface ifetch_unit_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                ecall;
  logic                continue_button;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus;
  logic                halted;
  logic                fetch_valid;
  logic                resume_pulse;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic                misalign;
`endif

  modport master (
`ifdef IFETCH_ALIGN_CHECK_EN
    input  misalign,
`endif
    output ecall, continue_button, stall, redirect_valid, redirect_pc,
    input  pc, pc_plus, halted, fetch_valid, resume_pulse
  );

  modport slave (
`ifdef IFETCH_ALIGN_CHECK_EN
    output misalign,
`endif
    input  ecall, continue_button, stall, redirect_valid, redirect_pc,
    output pc, pc_plus, halted, fetch_valid, resume_pulse
  );
endinterface

// File: rtl/ifetch_unit_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, release (1->0) edge detector.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DBC_WIDTH       = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic button_i,
  output logic release_o
);
  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic [DBC_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb begin
        level_d = sync2_q;
        cnt_d   = '0;
      end
    end else begin : g_count
      localparam logic [DBC_WIDTH-1:0] LAST = DBC_WIDTH'(DEBOUNCE_CYCLES - 1);
      // Count only while a change is pending; the level flips on the edge the count reaches DEBOUNCE_CYCLES.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == LAST) level_d = sync2_q;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
    end
  endgenerate

  assign release_o = level_q & ~level_d;
endmodule

// File: rtl/ifetch_unit.sv
// Program counter owner: sequential advance, redirects, ecall halt, debounced-button resume, stall.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect targets are refused and force HALT.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = 16,
  parameter int unsigned RESET_PC        = DEF_RESET_PC,
  parameter int unsigned INSTR_BYTES     = DEF_INSTR_BYTES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DBC_WIDTH       = 5
) (
  input logic          clock,
  input logic          reset,
  ifetch_unit_if.slave bus
);
  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(INSTR_BYTES);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus_w, next_pc;
  logic                pend_q, pend_d;
  logic                resume_q, resume_d;
  logic                release_edge;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
  logic misalign_q, misalign_d;
  logic target_bad;
  assign target_bad = bus.redirect_valid && ((bus.redirect_pc & ALIGN_MASK) != '0);
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DBC_WIDTH      (DBC_WIDTH)
  ) u_button (
    .clock    (clock),
    .reset    (reset),
    .button_i (bus.continue_button),
    .release_o(release_edge)
  );

  assign pc_plus_w = pc_q + PC_INC;
  assign next_pc   = bus.redirect_valid ? bus.redirect_pc : pc_plus_w;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RST;
      pend_q     <= 1'b0;
      resume_q   <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      resume_q   <= resume_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    resume_d   = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.ecall) state_d = ST_HALT;
`ifdef IFETCH_ALIGN_CHECK_EN
          else if (target_bad) begin
            state_d    = ST_HALT;
            misalign_d = 1'b1;
          end
`endif
          else pc_d = next_pc;
        end
      end
      ST_HALT: begin
        // A release seen under stall is remembered; further releases merge into it.
        if (release_edge || pend_q) begin
          if (bus.stall) pend_d = 1'b1;
          else begin
            pend_d = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (misalign_q) begin
              misalign_d = 1'b0;
              pc_d       = pc_plus_w;
              state_d    = ST_RUN;
              resume_d   = 1'b1;
            end else if (target_bad) misalign_d = 1'b1;
            else
`endif
            begin
              pc_d     = next_pc;
              state_d  = ST_RUN;
              resume_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus      = pc_plus_w;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.fetch_valid  = (state_q == ST_RUN) && !bus.stall;
  assign bus.resume_pulse = resume_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign bus.misalign     = misalign_q;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table with scoreboard, then hand sequences for halt/resume.
module tb_ifetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;

  ifetch_unit_if #(.PC_WIDTH(16)) bus ();

  ifetch_unit #(
    .PC_WIDTH       (16),
    .RESET_PC       (0),
    .INSTR_BYTES    (4),
    .DEBOUNCE_CYCLES(16),
    .DBC_WIDTH      (5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        ecall;
    logic        rv;
    logic [15:0] rpc;
    logic [15:0] exp_pc;
    logic        exp_halted;
    logic        exp_fv;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic        halted;
    logic        fv;
    logic        resume;
  } exp_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    exp_t        sb[$];
    exp_t        e;
    int unsigned lat, pulses, halts;
    logic [15:0] exp_pc, pc_at;

    vecs[0]  = '{0, 0, 0, 16'h0000, 16'h0004, 0, 1};
    vecs[1]  = '{0, 0, 0, 16'h0000, 16'h0008, 0, 1};
    vecs[2]  = '{0, 0, 0, 16'h0000, 16'h000C, 0, 1};
    vecs[3]  = '{0, 0, 0, 16'h0000, 16'h0010, 0, 1};
    vecs[4]  = '{0, 0, 1, 16'h0100, 16'h0100, 0, 1};
    vecs[5]  = '{1, 1, 1, 16'h0200, 16'h0100, 0, 0};
    vecs[6]  = '{0, 0, 1, 16'hFFFC, 16'hFFFC, 0, 1};
    vecs[7]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 1};
    vecs[8]  = '{0, 0, 1, 16'h001C, 16'h001C, 0, 1};
    vecs[9]  = '{0, 0, 0, 16'h0000, 16'h0020, 0, 1};
    vecs[10] = '{0, 1, 0, 16'h0000, 16'h0020, 1, 0};
    vecs[11] = '{0, 0, 1, 16'h0400, 16'h0020, 1, 0};

    bus.ecall = 0; bus.continue_button = 0; bus.stall = 0;
    bus.redirect_valid = 0; bus.redirect_pc = '0;
    #3;
    check("reset_pc", bus.pc, 16'h0000);
    check("reset_halted", bus.halted, 0);
    check("reset_fetch_valid", bus.fetch_valid, 1);
    check("reset_resume", bus.resume_pulse, 0);
    check("reset_pc_plus", bus.pc_plus, 16'h0004);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("reset_misalign", bus.misalign, 0);
`endif
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      bus.stall = vecs[i].stall; bus.ecall = vecs[i].ecall;
      bus.redirect_valid = vecs[i].rv; bus.redirect_pc = vecs[i].rpc;
      sb.push_back('{vecs[i].exp_pc, vecs[i].exp_halted, vecs[i].exp_fv, 1'b0});
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_pc", i), bus.pc, e.pc);
      check($sformatf("vec%0d_halted", i), bus.halted, e.halted);
      check($sformatf("vec%0d_fetch_valid", i), bus.fetch_valid, e.fv);
      check($sformatf("vec%0d_resume", i), bus.resume_pulse, e.resume);
    end
    bus.stall = 0; bus.ecall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;

    // A: halted at 0x20; press 30 clocks, release, resume 18 clocks later.
    bus.continue_button = 1;
    repeat (30) tick();
    check("A_pressed_halted", bus.halted, 1);
    check("A_pressed_pc", bus.pc, 16'h0020);
    bus.continue_button = 0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!bus.halted) begin lat = i; break; end
    end
    check("A_resume_latency", lat, 18);
    check("A_resume_pc", bus.pc, 16'h0024);
    check("A_resume_pulse", bus.resume_pulse, 1);
    bus.ecall = 1;
    tick();
    check("A_pulse_one_cycle", bus.resume_pulse, 0);
    check("A_rehalt", bus.halted, 1);
    check("A_rehalt_pc", bus.pc, 16'h0024);

    // B: chatter then release with ecall held -> exactly one resume, re-halt at 0x28.
    bus.continue_button = 1;
    repeat (20) tick();
    pulses = 0; pc_at = '0;
    for (int k = 0; k < 21; k++) begin
      bus.continue_button = ((k / 3) % 2 == 1);
      tick();
      if (bus.resume_pulse) begin pulses++; pc_at = bus.pc; end
    end
    bus.continue_button = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.resume_pulse) begin pulses++; pc_at = bus.pc; end
    end
    check("B_resume_count", pulses, 1);
    check("B_resume_pc", pc_at, 16'h0028);
    check("B_final_halted", bus.halted, 1);
    check("B_final_pc", bus.pc, 16'h0028);

    // C: two releases under stall -> stay halted; unstall resumes once onto the redirect.
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      bus.continue_button = 1;
      repeat (20) tick();
      bus.stall = 1;
      bus.continue_button = 0;
      for (int k = 0; k < 25; k++) begin
        tick();
        if (bus.resume_pulse) pulses++;
      end
    end
    check("C_stall_no_resume", pulses, 0);
    check("C_stall_halted", bus.halted, 1);
    check("C_stall_pc", bus.pc, 16'h0028);
    check("C_stall_fetch_valid", bus.fetch_valid, 0);
    bus.ecall = 0; bus.stall = 0; bus.redirect_valid = 1; bus.redirect_pc = 16'h0300;
    tick();
    check("C_resume_pc", bus.pc, 16'h0300);
    check("C_resume_pulse", bus.resume_pulse, 1);
    check("C_resume_halted", bus.halted, 0);
    bus.redirect_valid = 0;
    tick();
    check("C_single_resume", bus.resume_pulse, 0);
    check("C_advance_pc", bus.pc, 16'h0304);
    exp_pc = 16'h0304;

    // D: a release while running is discarded and leaves nothing pending.
    bus.continue_button = 1;
    repeat (20) tick();
    exp_pc += 16'd80;
    bus.continue_button = 0;
    pulses = 0; halts = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      exp_pc += 16'd4;
      if (bus.resume_pulse) pulses++;
      if (bus.halted) halts++;
    end
    check("D_run_pc", bus.pc, exp_pc);
    check("D_no_pulse", pulses, 0);
    check("D_never_halted", halts, 0);
    bus.ecall = 1;
    repeat (31) tick();
    check("D_halted_stays", bus.halted, 1);
    check("D_halted_pc", bus.pc, exp_pc);

    // E: async reset while halted with a pending resume.
    bus.continue_button = 1;
    repeat (20) tick();
    bus.stall = 1;
    bus.continue_button = 0;
    repeat (25) tick();
    check("E_pending_halted", bus.halted, 1);
    check("E_pending_pc", bus.pc, exp_pc);
    #3 reset = 1;
    #1;
    check("E_async_pc", bus.pc, 16'h0000);
    check("E_async_halted", bus.halted, 0);
    check("E_async_resume", bus.resume_pulse, 0);
    bus.stall = 0; bus.ecall = 0;
    tick();
    check("E_held_pc", bus.pc, 16'h0000);
    reset = 0;
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (bus.resume_pulse) pulses++;
    end
    check("E_restart_pc", bus.pc, 16'h0014);
    check("E_no_resume", pulses, 0);

`ifdef IFETCH_ALIGN_CHECK_EN
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0102;
    tick();
    check("M_misalign", bus.misalign, 1);
    check("M_halted", bus.halted, 1);
    check("M_pc", bus.pc, 16'h0014);
    bus.redirect_valid = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
